imul_ctrl: RTL and testbench

- Control unit for the TinyRV1 iterative shift-add multiplier (mul instruction).
- Sequences the multiplier datapath: operand registers A and B, and the result register.
- Drives their enables and mux selects. Sits between the decode/issue stage (istream) and writeback (ostream).
- Uses latency-insensitive val/rdy handshakes on both sides.

---
 rtl/imul_ctrl_pkg.sv | 20 ++
 rtl/imul_step_counter.sv | 27 ++
 rtl/imul_ctrl.sv | 96 +++++++++
 tb/tb_imul_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/imul_ctrl_pkg.sv
// Shared types and mux-select encodings for the iterative multiplier control unit.
package imul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;
  localparam logic SEL_ZERO  = 1'b0;
  localparam logic SEL_ADD   = 1'b1;

  // Step counter width; at least one bit so p_nbits=1 still elaborates.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imul_step_counter.sv
// Shift-add step counter: synchronous clear, increment, terminal flag at p_nbits-1.
module imul_step_counter
  import imul_ctrl_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_w(p_nbits);
  localparam logic [CW-1:0] LAST_CNT = CW'(p_nbits - 1);

  logic [CW-1:0] count;

  // Wraps to 0 at terminal so count never exceeds p_nbits-1.
  always_ff @(posedge clk) begin
    if (rst || clear)   count <= '0;
    else if (inc)       count <= last ? '0 : count + CW'(1);
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/imul_ctrl.sv
// Control FSM for the TinyRV1 iterative shift-add multiplier.
// Optional early exit on B==0 enabled by defining IMUL_EARLY_EXIT_EN.
module imul_ctrl
  import imul_ctrl_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic istream_val,
  output logic istream_rdy,
  output logic ostream_val,
  input  logic ostream_rdy,
  input  logic b_lsb,
  input  logic b_zero,
  output logic a_reg_en,
  output logic b_reg_en,
  output logic result_reg_en,
  output logic a_mux_sel,
  output logic b_mux_sel,
  output logic result_mux_sel,
  output logic add_mux_sel
);

  state_t state, state_n;
  logic   last;
  logic   early;

`ifdef IMUL_EARLY_EXIT_EN
  assign early = b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign early = 1'b0;
`endif

  imul_step_counter #(.p_nbits(p_nbits)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != CALC),
    .inc   (state == CALC),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (istream_val)        state_n = CALC;
      CALC:    if (early || last)      state_n = DONE;
      DONE:    if (ostream_rdy)        state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  // Outputs are held at zero throughout reset, including istream_rdy.
  always_comb begin
    istream_rdy    = 1'b0;
    ostream_val    = 1'b0;
    a_reg_en       = 1'b0;
    b_reg_en       = 1'b0;
    result_reg_en  = 1'b0;
    a_mux_sel      = SEL_LOAD;
    b_mux_sel      = SEL_LOAD;
    result_mux_sel = SEL_ZERO;
    add_mux_sel    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          istream_rdy = 1'b1;
          if (istream_val) begin
            a_reg_en      = 1'b1;
            b_reg_en      = 1'b1;
            result_reg_en = 1'b1;
          end
        end
        CALC: begin
          a_reg_en       = !early;
          b_reg_en       = !early;
          result_reg_en  = !early;
          a_mux_sel      = SEL_SHIFT;
          b_mux_sel      = SEL_SHIFT;
          result_mux_sel = SEL_ADD;
          add_mux_sel    = b_lsb;
        end
        DONE:    ostream_val = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imul_ctrl.sv
// Directed bench for imul_ctrl: latency, backpressure, reset abort, back-to-back, early exit.
module tb_imul_ctrl;

  logic clk = 1'b0;
  logic rst, istream_val, istream_rdy, ostream_val, ostream_rdy, b_lsb, b_zero;
  logic a_reg_en, b_reg_en, result_reg_en, a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imul_ctrl #(.p_nbits(32)) dut (
    .clk(clk), .rst(rst),
    .istream_val(istream_val), .istream_rdy(istream_rdy),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .b_lsb(b_lsb), .b_zero(b_zero),
    .a_reg_en(a_reg_en), .b_reg_en(b_reg_en), .result_reg_en(result_reg_en),
    .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel),
    .result_mux_sel(result_mux_sel), .add_mux_sel(add_mux_sel)
  );

  // {istream_rdy, ostream_val, a_en, b_en, r_en, a_sel, b_sel, r_sel, add_sel}
  wire [8:0] ctl = {istream_rdy, ostream_val, a_reg_en, b_reg_en, result_reg_en,
                    a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel};

  localparam logic [8:0] C_RST   = 9'b0_0_000_000_0;
  localparam logic [8:0] C_IDLE  = 9'b1_0_000_000_0;
  localparam logic [8:0] C_ACC   = 9'b1_0_111_000_0;
  localparam logic [8:0] C_CALC0 = 9'b0_0_111_111_0;
  localparam logic [8:0] C_CALC1 = 9'b0_0_111_111_1;
  localparam logic [8:0] C_DONE  = 9'b0_1_000_000_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    logic [3:0] lsb_pat;
    bit         seen;
    lsb_pat = 4'b1101;  // cycle1=1, cycle2=0, cycle3=1, cycle4=1 (bit index = cycle-1, reversed below)

    rst = 1'b1; istream_val = 1'b1; ostream_rdy = 1'b0; b_lsb = 1'b1; b_zero = 1'b0;
    tick; settle; chk("reset_outputs_zero_c0", ctl, C_RST);
    tick; settle; chk("reset_outputs_zero_c1", ctl, C_RST);

    // Test 1/2: accept in cycle 0, CALC cycles 1..32, DONE in 33.
    tick; rst = 1'b0; istream_val = 1'b1; b_lsb = 1'b0; settle;
    chk("t1_accept_c0", ctl, C_ACC);
    for (int c = 1; c <= 32; c++) begin
      tick; istream_val = 1'b0;
      b_lsb = (c == 1 || c == 3 || c == 4) ? 1'b1 : 1'b0;
      settle;
      chk($sformatf("t1_calc_c%0d", c), ctl, b_lsb ? C_CALC1 : C_CALC0);
    end
    b_lsb = 1'b0;
    // Test 3: backpressure for 5 DONE cycles.
    for (int c = 33; c <= 37; c++) begin
      tick; settle;
      chk($sformatf("t3_done_hold_c%0d", c), ctl, C_DONE);
    end
    tick; ostream_rdy = 1'b1; settle;
    chk("t3_done_handshake", ctl, C_DONE);
    tick; ostream_rdy = 1'b0; settle;
    chk("t3_back_to_idle", ctl, C_IDLE);

    // Test 4: reset during CALC cycle 10 aborts.
    istream_val = 1'b1; settle;
    chk("t4_accept", ctl, C_ACC);
    for (int c = 1; c <= 9; c++) begin
      tick; istream_val = 1'b0; settle;
      chk($sformatf("t4_calc_c%0d", c), ctl, C_CALC0);
    end
    tick; rst = 1'b1; settle;
    chk("t4_rst_mid_calc", ctl, C_RST);
    tick; rst = 1'b0; ostream_rdy = 1'b1; settle;
    chk("t4_idle_after_rst", ctl, C_IDLE);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick; settle;
      if (ostream_val) seen = 1'b1;
    end
    chk("t4_no_ostream_val", 32'(seen), 32'd0);

    // Test 5: back-to-back, accepts at 0/34/68, ostream_val at 33/67.
    istream_val = 1'b1; ostream_rdy = 1'b1;
    for (int c = 0; c <= 68; c++) begin
      if (c != 0) tick;
      settle;
      chk($sformatf("t5_ordy_c%0d", c), 32'(istream_rdy), 32'(c == 0 || c == 34 || c == 68));
      chk($sformatf("t5_oval_c%0d", c), 32'(ostream_val), 32'(c == 33 || c == 67));
    end
    istream_val = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick; settle;
      if (istream_rdy) seen = 1'b1;
    end
    chk("t5_drain_to_idle", 32'(seen), 32'd1);

    // Test 6: b_zero pulsed in CALC cycle 3.
    ostream_rdy = 1'b0; istream_val = 1'b1; settle;
    chk("t6_accept", ctl, C_ACC);
    for (int c = 1; c <= 2; c++) begin
      tick; istream_val = 1'b0; settle;
      chk($sformatf("t6_calc_c%0d", c), ctl, C_CALC0);
    end
    tick; b_zero = 1'b1; settle;
`ifdef IMUL_EARLY_EXIT_EN
    chk("t6_early_r_en", 32'(result_reg_en), 32'd0);
    chk("t6_early_a_en", 32'(a_reg_en), 32'd0);
    tick; b_zero = 1'b0; settle;
    chk("t6_early_done", ctl, C_DONE);
`else
    chk("t6_noearly_r_en", 32'(result_reg_en), 32'd1);
    for (int c = 4; c <= 32; c++) begin
      tick; b_zero = 1'b0; settle;
      chk($sformatf("t6_oval_low_c%0d", c), 32'(ostream_val), 32'd0);
    end
    tick; settle;
    chk("t6_done_c33", ctl, C_DONE);
`endif
    tick; ostream_rdy = 1'b1; settle;
    chk("t6_still_done", ctl, C_DONE);
    tick; settle;
    chk("t6_idle", ctl, C_IDLE);

    if (lsb_pat == 4'b0000) $display("unused");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
